// File: rtl/fwd_ctrl.sv
// fwd_ctrl: forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks in-flight destination info through EX/MEM/WB and drives the two
// EX operand-mux selects (00 = regfile, 01 = WB result, 10 = MEM result).
// Optional build macro FWD_CTRL_PERF_EN adds a saturating 16-bit stall counter
// on output stall_cnt.
module fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rs1,
  input  logic [REG_ADDR_W-1:0] iss_rs2,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic                  iss_regwrite,
  input  logic                  iss_memread,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall
`ifdef FWD_CTRL_PERF_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  // EX record keeps sources and the load flag; MEM/WB only need what a
  // consumer in EX compares against, so rs1/rs2/memread stop at EX.
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_regwrite_q, ex_regwrite_d;
  logic                  ex_memread_q, ex_memread_d;

  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_regwrite_q, mem_regwrite_d;

  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_regwrite_q, wb_regwrite_d;

  logic mem_writes;
  logic wb_writes;
  logic load_in_ex;

  // A stage can supply a forwarded value only if it is a live writer of a real register.
  always_comb begin
    mem_writes = mem_valid_q && mem_regwrite_q && (mem_rd_q != ZERO_ADDR);
    wb_writes  = wb_valid_q && wb_regwrite_q && (wb_rd_q != ZERO_ADDR);
    load_in_ex = ex_valid_q && ex_memread_q && ex_regwrite_q && (ex_rd_q != ZERO_ADDR);
  end

  // Operand selects: newest producer (MEM) wins over WB; bubbles in EX select the regfile.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_valid_q) begin
      if (mem_writes && (mem_rd_q == ex_rs1_q)) begin
        fwd_a = 2'b10;
      end else if (wb_writes && (wb_rd_q == ex_rs1_q)) begin
        fwd_a = 2'b01;
      end
      if (mem_writes && (mem_rd_q == ex_rs2_q)) begin
        fwd_b = 2'b10;
      end else if (wb_writes && (wb_rd_q == ex_rs2_q)) begin
        fwd_b = 2'b01;
      end
    end
  end

  // Load-use stall: a load in EX whose result the issuing instruction reads; a flush cancels it.
  always_comb begin
    stall = !flush && iss_valid && load_in_ex &&
            ((ex_rd_q == iss_rs1) || (ex_rd_q == iss_rs2));
  end

  // Next-state for the stage records: shift when not held, inject a bubble when the issue is dropped.
  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_rd_d        = ex_rd_q;
    ex_regwrite_d  = ex_regwrite_q;
    ex_memread_d   = ex_memread_q;
    mem_valid_d    = mem_valid_q;
    mem_rd_d       = mem_rd_q;
    mem_regwrite_d = mem_regwrite_q;
    wb_valid_d     = wb_valid_q;
    wb_rd_d        = wb_rd_q;
    wb_regwrite_d  = wb_regwrite_q;
    if (!hold) begin
      wb_valid_d     = mem_valid_q;
      wb_rd_d        = mem_rd_q;
      wb_regwrite_d  = mem_regwrite_q;
      mem_valid_d    = ex_valid_q;
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      if (flush || stall || !iss_valid) begin
        ex_valid_d    = 1'b0;
        ex_rs1_d      = '0;
        ex_rs2_d      = '0;
        ex_rd_d       = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
      end else begin
        ex_valid_d    = 1'b1;
        ex_rs1_d      = iss_rs1;
        ex_rs2_d      = iss_rs2;
        ex_rd_d       = iss_rd;
        ex_regwrite_d = iss_regwrite;
        ex_memread_d  = iss_memread;
      end
    end
  end

  // Stage record registers with synchronous reset discarding everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
    end
  end

`ifdef FWD_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count stall cycles that actually take effect (not frozen by hold), saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && !hold && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed test-plan sequences followed by random traffic,
// checked against a queue-based model of the instructions in flight.
module tb_fwd_ctrl;

  logic       clk;
  logic       rst;
  logic       hold;
  logic       flush;
  logic       iss_valid;
  logic [4:0] iss_rs1;
  logic [4:0] iss_rs2;
  logic [4:0] iss_rd;
  logic       iss_regwrite;
  logic       iss_memread;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       stall;
`ifdef FWD_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fwd_ctrl #(.REG_ADDR_W(5), .ZERO_REG(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .hold         (hold),
    .flush        (flush),
    .iss_valid    (iss_valid),
    .iss_rs1      (iss_rs1),
    .iss_rs2      (iss_rs2),
    .iss_rd       (iss_rd),
    .iss_regwrite (iss_regwrite),
    .iss_memread  (iss_memread),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall        (stall)
`ifdef FWD_CTRL_PERF_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: instructions in flight, newest first (index 0 = EX, 1 = MEM, 2 = WB).
  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  instr_t pipe[$];
  int     exp_cnt = 0;

  function automatic void modelReset();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back('0);
    exp_cnt = 0;
  endfunction

  // Nearest older writer of src wins: one step older -> MEM (2), two -> WB (1).
  function automatic logic [1:0] expFwd(input logic [4:0] src);
    if (!pipe[0].v) return 2'd0;
    for (int age = 1; age <= 2; age++) begin
      if (pipe[age].v && pipe[age].rw && pipe[age].rd != 5'd0 && pipe[age].rd == src)
        return (age == 1) ? 2'd2 : 2'd1;
    end
    return 2'd0;
  endfunction

  function automatic logic expStall();
    instr_t e;
    e = pipe[0];
    return !flush && iss_valid && e.v && e.mr && e.rw && e.rd != 5'd0 &&
           (e.rd == iss_rs1 || e.rd == iss_rs2);
  endfunction

  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic h, input logic f);
    iss_valid    = v;
    iss_rs1      = rs1;
    iss_rs2      = rs2;
    iss_rd       = rd;
    iss_regwrite = rw;
    iss_memread  = mr;
    hold         = h;
    flush        = f;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [1:0] ea;
    logic [1:0] eb;
    logic       es;
    ea = expFwd(pipe[0].rs1);
    eb = expFwd(pipe[0].rs2);
    es = expStall();
    checks++;
    assert (fwd_a === ea) else begin
      errors++;
      $error("[TB] FAIL %s fwd_a actual=%0d expected=%0d", tag, fwd_a, ea);
    end
    checks++;
    assert (fwd_b === eb) else begin
      errors++;
      $error("[TB] FAIL %s fwd_b actual=%0d expected=%0d", tag, fwd_b, eb);
    end
    checks++;
    assert (stall === es) else begin
      errors++;
      $error("[TB] FAIL %s stall actual=%0d expected=%0d", tag, stall, es);
    end
`ifdef FWD_CTRL_PERF_EN
    checks++;
    assert (stall_cnt === 16'(exp_cnt)) else begin
      errors++;
      $error("[TB] FAIL %s stall_cnt actual=%0d expected=%0d", tag, stall_cnt, exp_cnt);
    end
`endif
  endtask

  // Direct comparison against hand-derived constants from the test plan.
  task automatic expectNow(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                           input logic es);
    checks++;
    assert (fwd_a === ea && fwd_b === eb && stall === es) else begin
      errors++;
      $error("[TB] FAIL %s fwd_a/fwd_b/stall actual=%0d/%0d/%0d expected=%0d/%0d/%0d",
             tag, fwd_a, fwd_b, stall, ea, eb, es);
    end
  endtask

  // Advance the model by the rules, then let the DUT take the same edge.
  task automatic clockEdge();
    instr_t ni;
    logic   es;
    es = expStall();
    if (rst) begin
      modelReset();
    end else if (!hold) begin
      if (es && exp_cnt < 65535) exp_cnt++;
      ni = '0;
      if (iss_valid && !flush && !es) begin
        ni.v   = 1'b1;
        ni.rs1 = iss_rs1;
        ni.rs2 = iss_rs2;
        ni.rd  = iss_rd;
        ni.rw  = iss_regwrite;
        ni.mr  = iss_memread;
      end
      pipe.push_front(ni);
      void'(pipe.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic v, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                      input logic mr, input logic h, input logic f);
    applyStimulus(v, rs1, rs2, rd, rw, mr, h, f);
    checkOutput(tag);
    clockEdge();
  endtask

  task automatic idleCheck(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                           input logic es);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput(tag);
    expectNow(tag, ea, eb, es);
  endtask

  initial begin
    modelReset();
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clockEdge();
    clockEdge();
    rst = 1'b0;
    idleCheck("reset", 2'd0, 2'd0, 1'b0);

    // add x1 ; sub x5,x1,x2 -> sub in EX takes x1 from MEM
    step("add_x1", 1, 5'd2, 5'd3, 5'd1, 1, 0, 0, 0);
    step("sub_x5", 1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0);
    idleCheck("mem_fwd", 2'd2, 2'd0, 1'b0);
    clockEdge();

    // add x3 ; independent ; or x6,x2,x3 -> x3 from WB on B
    step("add_x3", 1, 5'd20, 5'd21, 5'd3, 1, 0, 0, 0);
    step("indep", 1, 5'd22, 5'd23, 5'd10, 1, 0, 0, 0);
    step("or_x6", 1, 5'd2, 5'd3, 5'd6, 1, 0, 0, 0);
    idleCheck("wb_fwd", 2'd0, 2'd1, 1'b0);
    clockEdge();

    // add x4 ; add x4 ; and x7,x4,x4 -> MEM beats WB
    step("add_x4a", 1, 5'd20, 5'd21, 5'd4, 1, 0, 0, 0);
    step("add_x4b", 1, 5'd20, 5'd21, 5'd4, 1, 0, 0, 0);
    step("and_x7", 1, 5'd4, 5'd4, 5'd7, 1, 0, 0, 0);
    idleCheck("mem_prio", 2'd2, 2'd2, 1'b0);
    clockEdge();

    // writer of x0 then reader of x0 -> never forwarded
    step("wr_x0", 1, 5'd20, 5'd21, 5'd0, 1, 0, 0, 0);
    applyStimulus(1, 5'd0, 5'd0, 5'd11, 1, 0, 0, 0);
    expectNow("x0_rd_issue", 2'd0, 2'd0, 1'b0);
    checkOutput("x0_rd_issue");
    clockEdge();
    idleCheck("x0_in_ex", 2'd0, 2'd0, 1'b0);
    clockEdge();
    idleCheck("x0_after", 2'd0, 2'd0, 1'b0);
    clockEdge();

    // lw x8 ; add x9,x8,x1 -> one stall cycle, bubble, then x8 from WB
    step("lw_x8", 1, 5'd2, 5'd0, 5'd8, 1, 1, 0, 0);
    applyStimulus(1, 5'd8, 5'd1, 5'd9, 1, 0, 0, 0);
    expectNow("lu_stall", 2'd0, 2'd0, 1'b1);
    checkOutput("lu_stall");
    clockEdge();
    applyStimulus(1, 5'd8, 5'd1, 5'd9, 1, 0, 0, 0);
    expectNow("lu_bubble", 2'd0, 2'd0, 1'b0);
    checkOutput("lu_bubble");
    clockEdge();
    applyStimulus(1, 5'd25, 5'd26, 5'd12, 1, 0, 0, 0);
    expectNow("lu_fwd", 2'd1, 2'd0, 1'b0);
    checkOutput("lu_fwd");
`ifdef FWD_CTRL_PERF_EN
    checks++;
    assert (stall_cnt === 16'd1) else begin
      errors++;
      $error("[TB] FAIL lu_cnt stall_cnt actual=%0d expected=1", stall_cnt);
    end
`endif

    // hold for 3 cycles with the dependent add in EX -> selects frozen
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 5'd25, 5'd26, 5'd12, 1, 0, 1, 0);
      expectNow("hold", 2'd1, 2'd0, 1'b0);
      checkOutput("hold");
      clockEdge();
    end
    applyStimulus(1, 5'd25, 5'd26, 5'd12, 1, 0, 0, 0);
    expectNow("hold_release", 2'd1, 2'd0, 1'b0);
    clockEdge();

    // flush a valid dependent issue -> EX is a bubble next cycle
    step("flush_src", 1, 5'd20, 5'd21, 5'd13, 1, 0, 0, 0);
    step("flush_issue", 1, 5'd13, 5'd13, 5'd14, 1, 0, 0, 1);
    idleCheck("flush_bubble", 2'd0, 2'd0, 1'b0);
    clockEdge();

    // reset mid-stream discards x15/x16 producers
    step("pre_rst_a", 1, 5'd20, 5'd21, 5'd15, 1, 0, 0, 0);
    step("pre_rst_b", 1, 5'd15, 5'd21, 5'd16, 1, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 5'd15, 5'd16, 5'd17, 1, 0, 0, 0);
    clockEdge();
    rst = 1'b0;
    idleCheck("rst_mid", 2'd0, 2'd0, 1'b0);
    step("post_rst_rd", 1, 5'd15, 5'd16, 5'd17, 1, 0, 0, 0);
    idleCheck("stale_gone", 2'd0, 2'd0, 1'b0);
    clockEdge();

    // random traffic over a small register set so matches are frequent
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(99, 0) < 2);
      step("random",
           $urandom_range(99, 0) < 80,
           5'($urandom_range(5, 0)), 5'($urandom_range(5, 0)), 5'($urandom_range(5, 0)),
           $urandom_range(99, 0) < 75, $urandom_range(99, 0) < 35,
           $urandom_range(99, 0) < 12, $urandom_range(99, 0) < 10);
    end
    rst = 1'b0;
    idleCheck("final_flush_out", expFwd(pipe[0].rs1), expFwd(pipe[0].rs2), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
Name: fwd_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage integer pipeline.
- Tracks destination-register info of in-flight instructions through EX/MEM/WB and drives the 2-bit select of the two EX-stage 3-to-1 operand muxes.
- Select encoding: 00 = register-file operand, 01 = WB result, 10 = MEM (ALU) result.
- Also detects load-use hazards and requests a one-cycle issue stall with bubble insertion.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- ZERO_REG, 0, register index that is never forwarded (hard-wired zero).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- hold  input  1  freeze all internal stage registers (downstream memory wait).
- flush  input  1  kill the instruction issuing from ID this cycle (branch taken).
- iss_valid  input  1  ID-stage instruction valid.
- iss_rs1  input  REG_ADDR_W  ID source register 1.
- iss_rs2  input  REG_ADDR_W  ID source register 2.
- iss_rd  input  REG_ADDR_W  ID destination register.
- iss_regwrite  input  1  ID instruction writes rd.
- iss_memread  input  1  ID instruction is a load.
- fwd_a  output  2  select for EX operand-A mux.
- fwd_b  output  2  select for EX operand-B mux.
- stall  output  1  load-use stall request to PC/ID registers.

Behaviour:
- Internal stage records EX, MEM and WB, each holding {valid, rs1, rs2, rd, regwrite, memread}.
  - rs1/rs2 are needed in EX only.
  - A record with valid=0 is a bubble and never matches.
- Reset: all record valid bits = 0 and all fields = 0. Consequently fwd_a = fwd_b = 00 and stall = 0 in the cycle after rst is sampled high. Reset mid-operation discards all in-flight records.
- Update priority per rising edge: rst > hold > normal.
  - hold=1: all records keep their values; flush and stall have no effect on state.
  - Normal:
    - WB <= MEM and MEM <= EX.
    - EX <= bubble if flush=1, stall=1 or iss_valid=0; otherwise EX <= iss_* fields with valid=1.
- stall (combinational from EX record and iss_*):
  - Asserted when EX.valid, EX.memread and EX.regwrite are all set, EX.rd != ZERO_REG, iss_valid=1, and EX.rd equals iss_rs1 or iss_rs2.
  - Forced to 0 when flush=1.
  - During hold, stall still reflects the current state, so it may be held high across hold cycles.
- A stalled instruction is re-presented by ID the next cycle. A single load-use produces exactly one stall cycle: next cycle the load is in MEM and no longer matches.
- fwd_a (combinational from records; fwd_b identical using EX.rs2):
  - 10 if MEM.valid, MEM.regwrite, MEM.rd != ZERO_REG and MEM.rd == EX.rs1.
  - else 01 if the same conditions hold for WB against EX.rs1.
  - else 00.
  - MEM match has priority over WB match (newest value).
  - 11 is never driven.
  - If EX.valid=0, outputs are 00.
- A load in MEM is never forwarded with 10, because the load-use stall guarantees that case cannot occur.
- Latency: an instruction accepted from ID at edge N occupies EX during cycle N+1; its fwd selects are valid throughout that cycle.
- Width rule: register comparisons are full REG_ADDR_W equality.

Optional Feature:
- Macro FWD_CTRL_PERF_EN.
- When defined, adds output stall_cnt (16 bits):
  - Increments by 1 on each clock edge where stall=1 and hold=0.
  - Saturates at 0xFFFF.
  - Cleared to 0 by rst.
- When undefined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
- After reset, issue "add x1" then "sub x5,x1,x2" back-to-back -> during cycle 2 (sub in EX): fwd_a=10, fwd_b=00, stall=0.
- Issue "add x3", one independent instruction, then "or x6,x2,x3" -> with or in EX: fwd_b=01, fwd_a=00.
- Issue "add x4", then "add x4", then "and x7,x4,x4" -> both MEM and WB match; expect fwd_a=fwd_b=10.
- Issue a writer with rd=x0 followed by a reader of x0 -> fwd_a=fwd_b=00 in all cycles.
- Load-use sequence:
  - Stimulus: issue "lw x8", then present "add x9,x8,x1" in ID.
  - Expect stall=1 for exactly 1 cycle and a bubble in EX (fwd=00).
  - The re-presented add then enters EX with fwd_a=01.
  - stall_cnt=1 when FWD_CTRL_PERF_EN is defined.
- Control and reset:
  - Assert hold for 3 cycles with the dependent in EX -> fwd outputs are held constant.
  - Assert flush with a valid issue -> EX becomes a bubble next cycle.
  - Assert rst mid-stream -> all outputs are 0 the next cycle, and stale MEM/WB matches no longer forward.
